// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer.
// The FAULT state exists only when FETCH_FAULT_EN is defined.
package fetch_pkg;

`ifdef FETCH_FAULT_EN
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    RUN
  } state_e;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer of {pc, instr} entries.
// Push and pop may coincide when full; order is preserved.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] head,
  output logic               w_valid,
  output logic [CW-1:0]      count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_rd;
  logic [AW-1:0]      r_wr;
  logic [CW-1:0]      r_cnt;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_wr <= nxt(r_wr);
      end
      if (pop) begin
        r_rd <= nxt(r_rd);
      end
      unique case ({push, pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign head    = r_mem[r_rd];
  assign w_valid = (r_cnt != '0);
  assign count   = r_cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// Sequential instruction fetch with redirect and a small output buffer.
// Define FETCH_FAULT_EN to trap misaligned or out-of-range fetches.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 4096,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e             r_state;
  state_e             w_next;
  logic [31:0]        r_pc;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_fetch;
  logic               w_valid;
  logic [CW-1:0]      w_cnt;
  logic [ENTRY_W-1:0] w_head;
  entry_t             w_wr;
  entry_t             w_hd;

`ifdef FETCH_FAULT_EN
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
  logic w_bad;
  assign w_bad = (r_pc[1:0] != 2'b00) || (r_pc > LAST_ADDR);
`else
  logic [31:0] w_unused_mem;
  assign w_unused_mem = 32'(MEM_BYTES);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_flush) begin
      r_pc <= redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_flush = 1'b0;
    w_fetch = 1'b0;
    w_push  = 1'b0;
    w_pop   = w_valid && out_ready;
    unique case (r_state)
      IDLE: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          w_pop   = 1'b0;
        end else if (enable) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          w_pop   = 1'b0;
        end else begin
          w_fetch = enable && ((w_cnt < CW'(DEPTH)) || w_pop);
          if (!enable) begin
            w_next = IDLE;
          end
`ifdef FETCH_FAULT_EN
          if (w_fetch && w_bad) begin
            w_next = FAULT;
          end else begin
            w_push = w_fetch;
          end
`else
          w_push = w_fetch;
`endif
        end
      end
      // FAULT: no fetches or redirects, buffered entries still drain
      default: begin
        w_next = r_state;
      end
    endcase
  end

  assign w_wr.pc    = r_pc;
  assign w_wr.instr = imem_data;

  fetch_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (w_push),
    .pop    (w_pop),
    .flush  (w_flush),
    .wdata  (w_wr),
    .head   (w_head),
    .w_valid(w_valid),
    .count  (w_cnt)
  );

  assign w_hd      = entry_t'(w_head);
  assign imem_addr = r_pc;
  assign out_valid = w_valid;
  assign out_pc    = w_valid ? w_hd.pc : '0;
  assign out_instr = w_valid ? w_hd.instr : '0;

`ifdef FETCH_FAULT_EN
  assign fault = (r_state == FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a cycle model and
// an expected-entry queue compared at the buffer head.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          MEM_BYTES = 4096;
  localparam int          DEPTH     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .MEM_BYTES(MEM_BYTES),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  assign imem_data = memw(imem_addr);

  int          total = 0;
  int          bad   = 0;
  logic [63:0] q[$];
  logic [31:0] m_pc;
  int          m_st;
  logic        m_fault;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic en, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic r);
    logic pop;
    logic fetch;
    logic badpc;
    @(negedge clk);
    enable         = en;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    rst            = r;
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("sb_pc", out_pc, q[0][63:32]);
      chk("sb_instr", out_instr, q[0][31:0]);
    end
    chk("fault", 32'(fault), 32'(m_fault));
    if (r) begin
      m_pc    = RESET_PC;
      m_st    = 0;
      m_fault = 1'b0;
      q.delete();
    end else begin
      pop = (q.size() != 0) && rdy;
      if (m_st != 2 && rv) begin
        q.delete();
        m_pc = rpc;
      end else begin
        fetch = (m_st == 1) && en && ((q.size() < DEPTH) || pop);
        if (pop) void'(q.pop_front());
        badpc = 1'b0;
`ifdef FETCH_FAULT_EN
        badpc = (m_pc[1:0] != 2'b00) || (m_pc > 32'(MEM_BYTES - 4));
`endif
        if (fetch && badpc) begin
          m_st    = 2;
          m_fault = 1'b1;
        end else begin
          if (fetch) begin
            q.push_back({m_pc, memw(m_pc)});
            m_pc = m_pc + 32'd4;
          end
          if (m_st == 0 && en) m_st = 1;
          else if (m_st == 1 && !en) m_st = 0;
        end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    m_pc    = RESET_PC;
    m_st    = 0;
    m_fault = 1'b0;

    // streaming
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    sample();
    chk("stream_addr4", imem_addr, 32'h4);
    chk("stream_pc0", out_pc, 32'h0);
    step(1, 1, 0, 0, 0);
    sample();
    chk("stream_addr8", imem_addr, 32'h8);
    chk("stream_pc4", out_pc, 32'h4);
    step(1, 1, 0, 0, 0);
    sample();
    chk("stream_pc8", out_pc, 32'h8);
    chk("stream_valid", 32'(out_valid), 32'h1);

    // backpressure
    step(0, 0, 0, 0, 1);
    repeat (7) step(1, 0, 0, 0, 0);
    sample();
    chk("bp_addr_hold", imem_addr, 32'h8);
    chk("bp_pc_hold", out_pc, 32'h0);
    step(1, 1, 0, 0, 0);
    sample();
    chk("bp_pc4", out_pc, 32'h4);
    step(1, 1, 0, 0, 0);
    sample();
    chk("bp_pc8", out_pc, 32'h8);

    // redirect while full
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h100, 0);
    sample();
    chk("rd_valid0", 32'(out_valid), 32'h0);
    chk("rd_addr", imem_addr, 32'h100);
    step(1, 1, 0, 0, 0);
    sample();
    chk("rd_pc", out_pc, 32'h100);

    // disable drains buffer, pc held
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    sample();
    chk("dis_valid0", 32'(out_valid), 32'h0);
    chk("dis_addr", imem_addr, 32'h108);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    sample();
    chk("dis_resume", out_pc, 32'h108);

    // reset beats redirect and pop
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h200, 1);
    sample();
    chk("rr_valid", 32'(out_valid), 32'h0);
    chk("rr_pc", out_pc, 32'h0);
    chk("rr_instr", out_instr, 32'h0);
    chk("rr_addr", imem_addr, RESET_PC);
    chk("rr_fault", 32'(fault), 32'h0);

`ifdef FETCH_FAULT_EN
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h102, 0);
    step(1, 1, 0, 0, 0);
    sample();
    chk("f_mis", 32'(fault), 32'h1);
    chk("f_mis_valid", 32'(out_valid), 32'h0);
    step(1, 1, 1, 32'h0, 0);
    sample();
    chk("f_sticky", 32'(fault), 32'h1);
    chk("f_addr", imem_addr, 32'h102);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'hFFC, 0);
    step(1, 1, 0, 0, 0);
    sample();
    chk("f_last_ok", 32'(fault), 32'h0);
    chk("f_last_pc", out_pc, 32'hFFC);
    step(1, 1, 0, 0, 0);
    sample();
    chk("f_oob", 32'(fault), 32'h1);
    step(1, 1, 0, 0, 0);
`else
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'hFFFF_FFFC, 0);
    step(1, 1, 0, 0, 0);
    sample();
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("nf_fault", 32'(fault), 32'h0);
    step(1, 1, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
